// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - F2D fetch-to-decode handshake interface
interface F2D;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ipd_t;

  typedef struct packed {
    ipd_t ipd;
  } f2d_data_t;

  logic      valid;
  logic      rdy;
  f2d_data_t data;

  modport master (output valid, output data, input rdy);
  modport slave  (input valid, input data, output rdy);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue feeding Decode over F2D (optional FETQ_PERF_EN stall counter)
module fetch_queue #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        cpu_halt,
  input  logic        pipe_flush,
  input  logic [31:0] flush_pc,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic [31:0] ic_rd_data,
  F2D.master          F2D_bus
`ifdef FETQ_PERF_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   inst_mem [QDEPTH];
  logic [31:0]   pc_mem   [QDEPTH];
  logic [31:0]   next_pc;
  logic [31:0]   flush_tgt;
  logic          issue, push, pop, head_valid;

  assign flush_tgt  = flush_pc & 32'hFFFF_FFFC;
  assign head_valid = (count != '0);
  assign pop        = head_valid && F2D_bus.rdy;
  assign ic_req     = (state != S_IDLE);

  assign F2D_bus.valid = head_valid;
  assign F2D_bus.data  = {inst_mem[rd_ptr], pc_mem[rd_ptr]};

  // Next-state decode: one outstanding read, an IDLE cycle between requests
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cpu_halt && !pipe_flush && (count < CW'(QDEPTH))) begin
          state_nxt = S_REQ;
          issue     = 1'b1;
        end
      end
      S_REQ: begin
        if (ic_ack) begin
          state_nxt = S_IDLE;
          push      = !pipe_flush;
        end else if (pipe_flush) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (ic_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Request address is latched at issue and held until the ack
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)  ic_addr <= 32'h0;
    else if (issue) ic_addr <= next_pc;
  end

  // Fetch PC: redirect wins over advancing on an accepted word
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)       next_pc <= RESET_PC;
    else if (pipe_flush) next_pc <= flush_tgt;
    else if (push)       next_pc <= next_pc + 32'd4;
  end

  // Queue pointers and occupancy; a flush empties the queue regardless of push/pop
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (pipe_flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Queue storage; cleared on reset so the F2D data bus starts at zero
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < QDEPTH; i++) begin
        inst_mem[i] <= 32'h0;
        pc_mem[i]   <= 32'h0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= ic_rd_data;
      pc_mem[wr_ptr]   <= ic_addr;
    end
  end

`ifdef FETQ_PERF_EN
  // Count cycles Decode holds off a valid word
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in)                       stall_cnt <= 32'h0;
    else if (head_valid && !F2D_bus.rdy) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset_in, cpu_halt, pipe_flush, ic_ack, ic_req;
  logic [31:0] flush_pc, ic_rd_data, ic_addr;
`ifdef FETQ_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] s0;
`endif

  F2D f2d();

  always #5 clk = ~clk;

  fetch_queue #(.QDEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .reset_in(reset_in), .cpu_halt(cpu_halt),
    .pipe_flush(pipe_flush), .flush_pc(flush_pc),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rd_data(ic_rd_data),
    .F2D_bus(f2d)
`ifdef FETQ_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] fpc;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[4];
  int          n_checks = 0, n_fail = 0;
  int          lat = 0, wait_cnt = 0, acks = 0, guard;
  logic        drop = 1'b0, prev_req = 1'b0, auto_on = 1'b0;
  logic [31:0] exp_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got timeout expected event", name);
  endtask

  // One clock: scoreboard pop, memory responder, then the edge
  task automatic step();
    exp_t e;
    logic acc;
    acc = 1'b0;
    if (ic_req && !prev_req) check("req_addr", ic_addr, exp_addr);
    prev_req = ic_req;
    if (f2d.valid && f2d.rdy && !pipe_flush) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", f2d.data.ipd.pc);
      end else begin
        e = sb.pop_front();
        check("pop_pc", f2d.data.ipd.pc, e.pc);
        check("pop_inst", f2d.data.ipd.inst, e.inst);
      end
    end
    ic_ack     = 1'b0;
    ic_rd_data = 32'hDEAD_BEEF;
    if (ic_req && auto_on) begin
      if (wait_cnt >= lat) begin
        ic_ack     = 1'b1;
        ic_rd_data = mem_word(ic_addr);
        wait_cnt   = 0;
        if (!drop && !pipe_flush) begin
          sb.push_back({ic_addr, mem_word(ic_addr)});
          exp_addr = ic_addr + 32'd4;
          acks++;
          acc = 1'b1;
        end
        drop = 1'b0;
      end else begin
        wait_cnt++;
      end
    end
    if (pipe_flush) begin
      sb.delete();
      exp_addr = flush_pc & 32'hFFFF_FFFC;
      if (ic_req && !ic_ack) drop = 1'b1;
    end
    @(posedge clk);
    #1;
    if (acc) check("valid_after_ack", 32'(f2d.valid), 32'h1);
    pipe_flush = 1'b0;
    ic_ack     = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_flush(input logic [31:0] pc);
    pipe_flush = 1'b1;
    flush_pc   = pc;
    step();
  endtask

  task automatic wait_req(input string name);
    guard = 0;
    while (!ic_req && guard < 50) begin
      step();
      guard++;
    end
    if (!ic_req) bound_fail(name);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_03FF, 32'h0000_03FC, 32'h0000_0400};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFFB, 32'hFFFF_FFF8, 32'hFFFF_FFFC};

    reset_in = 1'b0; cpu_halt = 1'b0; pipe_flush = 1'b0; flush_pc = 32'h0;
    ic_ack = 1'b0; ic_rd_data = 32'h0; f2d.rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ic_req", 32'(ic_req), 32'h0);
    check("rst_ic_addr", ic_addr, 32'h0);
    check("rst_valid", 32'(f2d.valid), 32'h0);
    check("rst_data_pc", f2d.data.ipd.pc, 32'h0);
    check("rst_data_inst", f2d.data.ipd.inst, 32'h0);
`ifdef FETQ_PERF_EN
    check("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    @(negedge clk);
    reset_in = 1'b1;
    auto_on  = 1'b1;
    step();
    check("first_req", 32'(ic_req), 32'h1);

    // Sequential fetch with zero-wait memory: one word per two cycles
    acks = 0;
    run(20);
    check("throughput_acks", 32'(acks), 32'd10);

    // Decode stalled: queue fills to QDEPTH and requests stop
    do_flush(32'h0);
    f2d.rdy = 1'b0;
    acks = 0;
    run(16);
    check("fill_acks", 32'(acks), 32'(QD));
    check("fill_no_req", 32'(ic_req), 32'h0);
    check("fill_valid", 32'(f2d.valid), 32'h1);
    f2d.rdy = 1'b1;
    run(12);

    // Redirect while the read of 0x8 is outstanding
    lat = 3;
    do_flush(32'h0);
    acks = 0;
    guard = 0;
    while (acks < 2 && guard < 100) begin
      step();
      guard++;
    end
    if (acks < 2) bound_fail("slow_acks");
    wait_req("req_0x8");
    check("pending_addr", ic_addr, 32'h8);
    step();
    do_flush(32'h100);
    check("flush_empty", 32'(f2d.valid), 32'h0);
    guard = 0;
    while (ic_req && guard < 20) begin
      step();
      guard++;
    end
    if (ic_req) bound_fail("discard_ack");
    wait_req("req_0x100");
    check("redirect_addr", ic_addr, 32'h100);
    run(12);

    // Flush coinciding with an ack and a pop
    lat = 0;
    f2d.rdy = 1'b0;
    guard = 0;
    while (!f2d.valid && guard < 20) begin
      step();
      guard++;
    end
    if (!f2d.valid) bound_fail("fill_one");
    wait_req("req_before_flush");
    f2d.rdy = 1'b1;
    check("pre_flush_valid", 32'(f2d.valid), 32'h1);
    do_flush(32'h200);
    check("ackflush_empty", 32'(f2d.valid), 32'h0);
    wait_req("req_0x200");
    check("ackflush_addr", ic_addr, 32'h200);
    run(6);

    // Redirect table including alignment and address wrap
    for (int v = 0; v < 4; v++) begin
      do_flush(vecs[v].fpc);
      wait_req("tbl_req0");
      check($sformatf("tbl%0d_addr0", v), ic_addr, vecs[v].a0);
      step();
      wait_req("tbl_req1");
      check($sformatf("tbl%0d_addr1", v), ic_addr, vecs[v].a1);
      run(4);
    end

    // Halt: outstanding read completes, then no new requests; output drains
    cpu_halt = 1'b1;
    run(3);
    acks = 0;
    run(10);
    check("halt_acks", 32'(acks), 32'h0);
    check("halt_no_req", 32'(ic_req), 32'h0);
    check("halt_drained", 32'(f2d.valid), 32'h0);
    cpu_halt = 1'b0;
    run(4);

`ifdef FETQ_PERF_EN
    f2d.rdy = 1'b0;
    guard = 0;
    while (!f2d.valid && guard < 20) begin
      step();
      guard++;
    end
    if (!f2d.valid) bound_fail("perf_valid");
    s0 = stall_cnt;
    run(10);
    check("stall_cnt", stall_cnt - s0, 32'd10);
    f2d.rdy = 1'b1;
    run(12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Fetch-side master of the F2D interface. Issues sequential instruction-word reads to the instruction memory port, buffers returned words with their PCs in a small FIFO, and presents them to the Decode stage using the F2D valid/rdy handshake. Handles misprediction redirects (`pipe_flush` + `flush_pc`) and `cpu_halt`, including a flush that arrives while a memory read is outstanding.

## Interface
- `QDEPTH`, 4: FIFO entries; power of 2, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk_in` in 1: single clock; all state on rising edge.
- `reset_in` in 1: asynchronous, active-low reset.
- `cpu_halt` in 1: 1 = issue no new memory requests.
- `pipe_flush` in 1: 1 = discard queue and redirect to `flush_pc`.
- `flush_pc` in 32: redirect target; bits [1:0] ignored (forced 0).
- `ic_req` out 1: instruction read request.
- `ic_addr` out 32: word-aligned read address.
- `ic_ack` in 1: read complete; `ic_rd_data` valid this cycle.
- `ic_rd_data` in 32: instruction word.
- `F2D_bus` F2D.master: drives `valid`, `data.ipd.inst`, `data.ipd.pc`; samples `rdy`.
- `stall_cnt` out 32: present only with `FETQ_PERF_EN`.

## Operation
- FIFO: `QDEPTH` entries of {inst[31:0], pc[31:0]}; `count` 0..QDEPTH; read/write pointers wrap modulo QDEPTH.
- `next_pc` register: address of next fetch; +4 per accepted (non-discarded) ack; wraps 32'hFFFF_FFFC → 0.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: if `!cpu_halt && !pipe_flush && count < QDEPTH` → REQ, `ic_addr <= next_pc`.
  - REQ: `ic_req`=1, `ic_addr` stable until `ic_ack`. On ack without flush: push {ic_rd_data, ic_addr}, `next_pc += 4`, → IDLE. On `pipe_flush` without ack: → DISCARD, `next_pc <= flush_pc`. On flush with ack same cycle: data dropped, `next_pc <= flush_pc`, → IDLE.
  - DISCARD: `ic_req`=1, `ic_addr` unchanged until `ic_ack`; data dropped; → IDLE. Further `pipe_flush` here updates `next_pc` only.
- Only one outstanding request; request is never withdrawn before ack.
- Pop when `F2D_bus.valid && F2D_bus.rdy`.
- `pipe_flush`: `count <= 0`, pointers reset; overrides any pop/push same cycle. `pipe_flush` in IDLE: `next_pc <= flush_pc`, no request that cycle.
- Push at count==QDEPTH cannot occur: IDLE only issues with count<QDEPTH and count never grows while REQ/DISCARD pending except by that request.

## Timing
- Reset values: `ic_req`=0, `ic_addr`=0, `F2D_bus.valid`=0, `F2D_bus.data`=0, `next_pc`=RESET_PC, count=0, state IDLE, `stall_cnt`=0.
- First `ic_req` one cycle after reset deasserts.
- `F2D_bus.valid` = (count≠0), registered; `F2D_bus.data` = head entry. Ack in cycle N → valid in N+1.
- Back-to-back: IDLE between requests, so max throughput 1 word per 2 cycles with zero-wait memory.
- Simultaneous push and pop: count unchanged.
- `cpu_halt` does not block an outstanding request nor F2D output.

## Configuration
- `FETQ_PERF_EN` defined: `stall_cnt` port exists; increments (wrapping) each cycle `F2D_bus.valid && !F2D_bus.rdy`; cleared by reset only.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset release, `ic_ack` one cycle after each `ic_req`, `rdy`=1 → addresses 0,4,8,…; F2D pc/inst match memory, valid the cycle after each ack.
- `rdy`=0, QDEPTH=4 → exactly 4 acks accepted, `ic_req` stays 0 afterward; raise `rdy` → entries drain in order pc 0,4,8,12.
- `pipe_flush` with `flush_pc`=32'h100 while REQ for 0x8 pending, ack 3 cycles later → ack data dropped, next `ic_addr`=0x100, queue empty, no pc 0x8 on F2D.
- `pipe_flush` with `flush_pc`=32'h200 on same cycle as ack and pop → count=0, data dropped, next request 0x200.
- `next_pc`=32'hFFFF_FFFC, one ack → following `ic_addr`=0.
- With `FETQ_PERF_EN`, hold `rdy`=0 for 10 cycles with valid=1 → `stall_cnt`=10.
